lcd_display_nios2_qsys_0_oci_dct_packer: RTL
============================================

// Module: lcd_display_nios2_qsys_0_oci_dct_packer
// PURPOSE
//   Packs 3-bit OCI data-compression-trace atoms into 30-bit words (up to 10 atoms) plus an atom count.
//   Sits directly upstream of the OCI test bench / trace FIFO and drives its dct_buffer, dct_count,
//   test_ending and test_has_ended inputs.
//   Accumulator plus output register (double buffer): packing continues while a finished word waits
//   for the consumer.
// PARAMETERS
//   ATOM_W  3   bits per trace atom
//   ATOMS   10  atoms per word; word width = ATOM_W*ATOMS = 30
//   CNT_W   4   count width; must hold ATOMS
// PORTS
//   clk             in   1   single clock; all logic on rising edge
//   reset_n         in   1   synchronous, active-low reset
//   atom_valid      in   1   producer presents an atom
//   atom_data       in   3   atom value
//   atom_ready      out  1   packer accepts the atom this cycle (transfer = atom_valid & atom_ready)
//   flush           in   1   one-cycle pulse: emit the partial word, then signal end
//   dct_buffer      out  30  packed word; atom k at bits [3k+2:3k]; unused bits 0
//   dct_count       out  4   number of valid atoms in dct_buffer, 1..10
//   dct_valid       out  1   dct_buffer/dct_count valid
//   dct_ready       in   1   consumer takes the word (transfer = dct_valid & dct_ready)
//   test_ending     out  1   high while a flush is pending or draining
//   test_has_ended  out  1   sticky; set when the flush completes; cleared only by reset
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): acc=0, acc_cnt=0, state=FILL; all outputs 0 (dct_buffer, dct_count,
//     dct_valid, test_ending, test_has_ended; atom_ready=0 during the reset cycle). Reset mid-word or
//     mid-flush discards everything, including a word waiting in the output register.
//   slot_free = !dct_valid | dct_ready. The output register loads from acc only when slot_free.
//   States:
//     FILL:  atom_ready=1. On accept: acc[3*acc_cnt +: 3]=atom_data, acc_cnt+1.
//            An accept that makes acc_cnt==10 -> FULL.
//            On flush (flush has priority; an atom_valid in the same cycle is not accepted, atom_ready=0):
//            -> FLUSH, test_ending=1.
//     FULL:  atom_ready=0. When slot_free: load out from acc (count 10), clear acc/acc_cnt -> FILL.
//            A flush arriving in FULL is latched; after the load -> FLUSH, not FILL.
//     FLUSH: atom_ready=0.
//            - If acc_cnt>0 and slot_free: load the partial word (count=acc_cnt, upper bits 0) and clear acc.
//            - Once acc_cnt==0 and the output register has drained (dct_valid=0 or transfer this cycle):
//              test_ending->0, test_has_ended->1, -> DONE.
//            - acc_cnt==0 at flush entry: no word is emitted; DONE follows 1 cycle later.
//     DONE:  atom_ready=0; further flush pulses are ignored; leave only by reset.
//   Latency: 10th atom accepted at edge N -> FULL; word loaded at edge N+1 (dct_valid visible after
//     N+1) if the slot is free.
//   Sustained throughput: 10 atoms per 11 cycles.
//   dct_valid holds, with dct_buffer and dct_count stable, until dct_ready. Load and consumer take in the
//     same cycle is legal (back-to-back words, no bubble).
//   dct_count is never 0 while dct_valid=1. dct_count and dct_buffer are 0 whenever dct_valid=0.
//   No wrap: acc_cnt saturates at 10 because atom_ready=0 in FULL.
// TESTING
//   1 Accept 10 atoms 0..7,0,1 with dct_ready=1. Required: dct_valid for 1 cycle, dct_count=10,
//     dct_buffer=30'o1076543210.
//   2 dct_ready=0, send 20 atoms of value 5. Required: first word is held; atom_ready drops after the
//     20th atom; raising dct_ready gives two words, each 30'o5555555555, count 10, back-to-back.
//   3 Send 3 atoms (1,2,3), then pulse flush. Required: word 30'o321, count 3; test_ending high until
//     that word is taken; then test_has_ended=1; atom_ready stays 0.
//   4 Flush with an empty accumulator and idle output. Required: no dct_valid; test_has_ended=1 two
//     cycles after the flush pulse.
//   5 atom_valid and flush in the same cycle. Required: the atom is not accepted; the partial word
//     excludes it.
//   6 Assert reset_n=0 while dct_valid=1 with 4 atoms in acc. Required: next cycle all outputs are 0;
//     then a 10-atom word packs from bit 0.

Source files
------------

// File: rtl/lcd_display_nios2_qsys_0_oci_dct_packer.sv
// lcd_display_nios2_qsys_0_oci_dct_packer: packs 3-bit trace atoms into 30-bit words with a double-buffered output
module lcd_display_nios2_qsys_0_oci_dct_packer #(
  parameter int ATOM_W = 3,
  parameter int ATOMS  = 10,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    atom_valid,
  input  logic [ATOM_W-1:0]       atom_data,
  output logic                    atom_ready,
  input  logic                    flush,
  output logic [ATOM_W*ATOMS-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    dct_valid,
  input  logic                    dct_ready,
  output logic                    test_ending,
  output logic                    test_has_ended
);
  localparam int W  = ATOM_W * ATOMS;
  localparam int IW = $clog2(W);
  typedef enum logic [1:0] {FILL, FULL, FLUSH, DONE} state_t;
  state_t         state, state_nx;
  logic [W-1:0]   acc;
  logic [CNT_W-1:0] acc_cnt;
  logic [IW-1:0]  idx;
  logic           flush_pend, slot_free, accept, load, finish;
  // handshake decode and next-state selection; flush in FILL beats an incoming atom
  always_comb begin
    slot_free  = !dct_valid || dct_ready;
    atom_ready = reset_n && state == FILL && !flush;
    accept     = atom_valid && atom_ready;
    load       = slot_free && (state == FULL || (state == FLUSH && acc_cnt != '0));
    finish     = state == FLUSH && acc_cnt == '0 && slot_free;
    idx        = IW'(acc_cnt) * IW'(ATOM_W);
    state_nx   = state;
    if (state == FILL && flush) state_nx = FLUSH;
    else if (accept && acc_cnt == CNT_W'(ATOMS - 1)) state_nx = FULL;
    else if (state == FULL && load) state_nx = (flush_pend || flush) ? FLUSH : FILL;
    else if (finish) state_nx = DONE;
  end
  // state register
  always_ff @(posedge clk) state <= !reset_n ? FILL : state_nx;
  // accumulator, output register and end-of-test flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc            <= '0;
      acc_cnt        <= '0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      flush_pend     <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (load) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else if (accept) begin
        acc     <= acc | (W'(atom_data) << idx);
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (load) begin
        dct_buffer <= acc;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
      end else if (dct_ready) begin
        dct_buffer <= '0;
        dct_count  <= '0;
        dct_valid  <= 1'b0;
      end
      flush_pend <= state == FULL && (flush_pend || flush);
      if ((state == FILL || state == FULL) && flush) test_ending <= 1'b1;
      if (finish) begin
        test_ending    <= 1'b0;
        test_has_ended <= 1'b1;
      end
    end
  end
endmodule
